// File: rtl/score_pkg.sv
// Shared types and helpers for the snake-game score tracker.
package score_pkg;

   localparam int unsigned SCORE_W_DEF  = 7;
   localparam int unsigned SCORE_WIDE_W = 16;

   typedef logic [SCORE_WIDE_W-1:0] score_wide_t;

   typedef enum logic {
      PLAYING   = 1'b0,
      GAME_OVER = 1'b1
   } state_t;

   // Unsigned maximum; callers zero-extend narrower scores to score_wide_t.
   function automatic score_wide_t max_score(input score_wide_t a, input score_wide_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/score_counter.sv
// Current-score counter: saturating increment with a load-to-one for a new game.
module score_counter
   import score_pkg::*;
#(
   parameter int unsigned W = SCORE_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         load1,
   input  logic [W-1:0] max,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load1) begin
         count <= W'(1);
      end else if (inc && (count < max)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/score_tracker.sv
// Score tracker: game FSM, session high score and display mux for the snake game.
module score_tracker
   import score_pkg::*;
#(
   parameter int unsigned SCORE_W   = SCORE_W_DEF,
   parameter int unsigned MAX_SCORE = 99
) (
   input  logic               clk,
   input  logic               nRst,
   input  logic               goodColl,
   input  logic               badColl,
   output logic [SCORE_W-1:0] dispScore,
   output logic               isGameComplete
);

   localparam logic [SCORE_W-1:0] MAX_V    = SCORE_W'(MAX_SCORE);
   localparam logic [SCORE_W-1:0] MAX_M1_V = SCORE_W'(MAX_SCORE - 1);

   state_t             state;
   logic [SCORE_W-1:0] cur_score;
   logic [SCORE_W-1:0] high_score;
   logic               playing;
   logic               cnt_inc;
   logic               cnt_load1;
   logic [SCORE_W-1:0] best_cur;
   logic [SCORE_W-1:0] best_max;

   assign playing   = (state == PLAYING);
   // A bad collision wins over an apple in the same cycle while playing.
   assign cnt_inc   = playing && goodColl && !badColl;
   assign cnt_load1 = !playing && goodColl;

   assign best_cur = SCORE_W'(max_score(SCORE_WIDE_W'(high_score), SCORE_WIDE_W'(cur_score)));
   assign best_max = SCORE_W'(max_score(SCORE_WIDE_W'(high_score), SCORE_WIDE_W'(MAX_V)));

   score_counter #(
      .W (SCORE_W)
   ) u_counter (
      .clk   (clk),
      .rst   (nRst),
      .inc   (cnt_inc),
      .load1 (cnt_load1),
      .max   (MAX_V),
      .count (cur_score)
   );

   always_ff @(posedge clk) begin
      if (nRst) begin
         state      <= PLAYING;
         high_score <= '0;
      end else begin
         case (state)
            PLAYING: begin
               if (badColl) begin
                  high_score <= best_cur;
                  state      <= GAME_OVER;
               end else if (goodColl && (cur_score == MAX_M1_V)) begin
                  high_score <= best_max;
                  state      <= GAME_OVER;
               end
            end
            GAME_OVER: begin
               if (goodColl) begin
                  state <= PLAYING;
               end
            end
            default: state <= PLAYING;
         endcase
      end
   end

   assign dispScore      = (state == GAME_OVER) ? high_score : cur_score;
   assign isGameComplete = (state == GAME_OVER);

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker.
module tb_score_tracker;

   localparam int unsigned SCORE_W   = 7;
   localparam int unsigned MAX_SCORE = 99;

   logic               tb_clk;
   logic               nRst;
   logic               goodColl;
   logic               badColl;
   logic [SCORE_W-1:0] dispScore;
   logic               isGameComplete;

   int total;
   int bad;

   score_tracker #(
      .SCORE_W   (SCORE_W),
      .MAX_SCORE (MAX_SCORE)
   ) dut (
      .clk            (tb_clk),
      .nRst           (nRst),
      .goodColl       (goodColl),
      .badColl        (badColl),
      .dispScore      (dispScore),
      .isGameComplete (isGameComplete)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic step(input logic g, input logic b);
      goodColl = g;
      badColl  = b;
      @(posedge tb_clk);
      #1;
      goodColl = 1'b0;
      badColl  = 1'b0;
   endtask

   task automatic rst_edge(input logic g, input logic b);
      nRst = 1'b1;
      step(g, b);
      nRst = 1'b0;
   endtask

   task automatic chk(input string tag, input int exp_disp, input logic exp_gc);
      total++;
      assert (dispScore === SCORE_W'(exp_disp)) else begin
         bad++;
         $error("FAIL %s disp: observed=%0d expected=%0d", tag, dispScore, exp_disp);
      end
      total++;
      assert (isGameComplete === exp_gc) else begin
         bad++;
         $error("FAIL %s gc: observed=%0b expected=%0b", tag, isGameComplete, exp_gc);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      nRst     = 1'b1;
      goodColl = 1'b0;
      badColl  = 1'b0;

      // Power-on reset held for two edges
      step(1'b0, 1'b0);
      chk("por1", 0, 1'b0);
      step(1'b0, 1'b0);
      chk("por2", 0, 1'b0);
      nRst = 1'b0;

      // Counting
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("count%0d", i), i, 1'b0);
      end

      // Bad collision then idle
      rst_edge(1'b0, 1'b0);
      chk("rst_a", 0, 1'b0);
      step(1'b1, 1'b0);
      chk("bc_good", 1, 1'b0);
      step(1'b0, 1'b1);
      chk("bc_bad", 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         chk($sformatf("bc_idle%0d", i), 1, 1'b1);
      end
      step(1'b0, 1'b1);
      chk("go_bad_ignored", 1, 1'b1);

      // High-score retention across games
      rst_edge(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("hs_g1", 2, 1'b0);
      step(1'b0, 1'b1);
      chk("hs_g1_over", 2, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("hs_g2_%0d", i), i, 1'b0);
      end
      step(1'b0, 1'b1);
      chk("hs_g2_over", 4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         chk($sformatf("hs_g2_idle%0d", i), 4, 1'b1);
      end
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("hs_g3_%0d", i), i, 1'b0);
      end
      step(1'b0, 1'b1);
      chk("hs_g3_over", 4, 1'b1);

      // Simultaneous good+bad with high above current
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b0);
      chk("sim_hi_pre", 3, 1'b0);
      step(1'b1, 1'b1);
      chk("sim_hi", 4, 1'b1);

      // Simultaneous good+bad from a cleared high score: no increment
      rst_edge(1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("sim_noinc", 3, 1'b1);
      step(1'b1, 1'b1);
      chk("go_restart_both", 1, 1'b0);

      // Saturation at MAX_SCORE
      rst_edge(1'b0, 1'b0);
      for (int i = 1; i <= 98; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("sat%0d", i), i, 1'b0);
      end
      step(1'b1, 1'b0);
      chk("sat_max", 99, 1'b1);
      step(1'b0, 1'b0);
      chk("sat_hold", 99, 1'b1);
      step(1'b1, 1'b0);
      chk("sat_restart", 1, 1'b0);
      step(1'b0, 1'b1);
      chk("sat_high_kept", 99, 1'b1);

      // Reset mid-game
      rst_edge(1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      chk("mid_high4", 4, 1'b1);
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0);
      chk("mid_score5", 5, 1'b0);
      rst_edge(1'b1, 1'b0);
      chk("mid_rst", 0, 1'b0);
      step(1'b0, 1'b1);
      chk("mid_after_bad", 0, 1'b1);

      // Reset has priority from GAME_OVER, with both inputs high
      rst_edge(1'b1, 1'b1);
      chk("rst_prio", 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
# score_tracker

Tracks the player's score and the session high score for the snake game. It counts good collisions (apple eaten) during play, ends the game on a bad collision or on reaching the maximum score, and keeps a high score across games. It drives one 7-bit value to the score display and a game-complete flag to the game controller.

## Interface
Parameters:
- SCORE_W, 7: width of score registers and of dispScore.
- MAX_SCORE, 99: saturation value of the current score. Reaching it ends the game. Must be ≤ 2^SCORE_W−1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nRst  input  1  synchronous, active-high reset. nRst=1 at a rising clk edge clears all state.
- goodColl  input  1  snake ate an apple. Sampled every cycle; each high cycle counts as one event.
- badColl  input  1  snake hit a wall or itself. Sampled every cycle.
- dispScore  output  SCORE_W  score to display. Current score while playing, high score when the game is over.
- isGameComplete  output  1  high while in GAME_OVER.

## Operation
- State register: PLAYING, GAME_OVER. Registers: curScore[SCORE_W], highScore[SCORE_W].
- Reset: state=PLAYING, curScore=0, highScore=0.
- PLAYING:
  - badColl=1: highScore←max(highScore,curScore), go to GAME_OVER. curScore is held. goodColl in the same cycle is ignored.
  - Else goodColl=1 and curScore<MAX_SCORE−1: curScore←curScore+1.
  - Else goodColl=1 and curScore=MAX_SCORE−1: curScore←MAX_SCORE, highScore←max(highScore,MAX_SCORE), go to GAME_OVER.
  - Neither input: hold.
- GAME_OVER:
  - goodColl=1 (badColl ignored): starts a new game. curScore←1, state←PLAYING. highScore is retained.
  - badColl alone: ignored. No other inputs change state.
- dispScore = (state==GAME_OVER) ? highScore : curScore. Combinational decode of registers only; no input-to-output path.
- isGameComplete = (state==GAME_OVER).
- Arithmetic is unsigned. curScore never exceeds MAX_SCORE and never wraps. highScore compare is unsigned.

## Timing
- Single clock domain. Outputs are glitch-free functions of registers.
- Latency: an event sampled at edge N is reflected on dispScore and isGameComplete after edge N (visible in cycle N+1).
- Back-to-back goodColl cycles increment once per cycle.
- Reset has priority over all inputs at the same edge. Reset mid-game or in GAME_OVER returns to PLAYING with both scores 0 on the next edge.
- Outputs during reset assertion: dispScore=0, isGameComplete=0 from the first reset edge onward.

## Structure
- Package score_pkg: SCORE_W default, state enum type (PLAYING, GAME_OVER), and a helper function max_score(a,b).
- One optional sub-module: score_counter, a saturating increment/load counter with inputs inc, load1, max and output count. The top holds the FSM, the highScore register and the output mux.

## Test plan
- Power-on reset: hold nRst=1 for 2 edges → dispScore=0, isGameComplete=0, both held while reset stays high.
- Counting: after reset, 4 single-cycle goodColl pulses → dispScore 1,2,3,4 after each pulse; isGameComplete=0 throughout.
- Bad collision: after one goodColl (score 1), pulse badColl → dispScore=1, isGameComplete=1. Five further idle cycles → unchanged.
- High-score retention: play to 2, badColl → disp 2. Then goodColl ×4 → disp 1,2,3,4 with isGameComplete=0. Then badColl and 5 idle cycles → disp 4. A third game ending at 3 → disp stays 4.
- Simultaneous and saturation cases:
  - goodColl+badColl together in PLAYING at score 3 → GAME_OVER, disp=max(high,3), no increment.
  - Score driven to MAX_SCORE → isGameComplete=1, disp=MAX_SCORE, extra goodColl restarts the game at 1.
- Reset mid-game: at score 5 with high score 4, assert nRst for 1 edge → disp=0, highScore cleared. A following badColl shows disp=0.
